// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family: bit-order encoding and
// the width helper used for bit counters.
package shift_pkg;

   typedef enum logic {
      DIR_LSB_FIRST = 1'b0,
      DIR_MSB_FIRST = 1'b1
   } dir_e;

   // Counter width able to hold the values 0..width.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/word_hold.sv
// One-entry valid/ready holding register. A load is accepted when empty or
// when the held word drains in the same cycle; otherwise it is reported as dropped.
module word_hold #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ready,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             drop
);

   logic [WIDTH-1:0] r_data;
   logic             r_full;
   logic             w_room;

   assign w_room = ~r_full | ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_full <= 1'b0;
      end else if (load && w_room) begin
         r_data <= data_in;
         r_full <= 1'b1;
      end else if (r_full && ready) begin
         r_full <= 1'b0;
      end
   end

   assign data_out = r_data;
   assign full     = r_full;
   assign drop     = load & ~w_room;

endmodule

// File: rtl/serial_deser8b.sv
// Serial-to-parallel receiver: assembles WIDTH strobed bits (LSB- or MSB-first,
// order latched per word) and presents each word through a one-word hold stage.
module serial_deser8b
   import shift_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CW    = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sin,
   input  logic             dir,
   input  logic             clr,
   output logic [WIDTH-1:0] pout,
   output logic             pvalid,
   input  logic             pready,
   output logic             overrun,
   output logic [CW-1:0]    bitcnt
);

   logic [WIDTH-1:0] r_asm;
   logic [CW-1:0]    r_bitcnt;
   dir_e             r_order;
   logic             r_overrun;

   logic             w_accept;
   logic             w_first;
   dir_e             w_order;
   logic [WIDTH-1:0] w_shifted;
   logic             w_complete;
   logic             w_drop;

   assign w_accept   = en & ~clr;
   assign w_first    = (r_bitcnt == '0);
   // The first bit of a word uses the live dir so the order applies to it too.
   assign w_order    = w_first ? dir_e'(dir) : r_order;
   assign w_complete = w_accept & (r_bitcnt == CW'(WIDTH - 1));

   always_comb begin
      w_shifted = r_asm;
      if (w_order == DIR_LSB_FIRST) begin
         w_shifted = {sin, r_asm[WIDTH-1:1]};
      end else begin
         w_shifted = {r_asm[WIDTH-2:0], sin};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_asm    <= '0;
         r_bitcnt <= '0;
         r_order  <= DIR_LSB_FIRST;
      end else if (clr) begin
         r_asm    <= '0;
         r_bitcnt <= '0;
      end else if (en) begin
         r_asm <= w_shifted;
         if (w_first) begin
            r_order <= dir_e'(dir);
         end
         if (w_complete) begin
            r_bitcnt <= '0;
         end else begin
            r_bitcnt <= r_bitcnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end
   end

   word_hold #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load    (w_complete),
      .data_in (w_shifted),
      .ready   (pready),
      .data_out(pout),
      .full    (pvalid),
      .drop    (w_drop)
   );

   assign overrun = r_overrun;
   assign bitcnt  = r_bitcnt;

endmodule

// File: tb/tb_serial_deser8b.sv
// Self-checking bench for serial_deser8b: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_serial_deser8b;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst, en, sin, dir, clr, pready;
   logic [W-1:0] pout;
   logic         pvalid, overrun;
   logic [3:0]   bitcnt;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic         m_bits[$];
   logic         m_ord;
   logic [W-1:0] m_pout;
   logic         m_valid;
   logic         m_over;

   typedef struct {
      logic [7:0] seq;
      logic       d;
      logic [7:0] exp;
   } vec_t;

   vec_t vt[7];

   serial_deser8b #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .sin    (sin),
      .dir    (dir),
      .clr    (clr),
      .pout   (pout),
      .pvalid (pvalid),
      .pready (pready),
      .overrun(overrun),
      .bitcnt (bitcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      logic [W-1:0] word;
      logic         done;
      logic         drain;
      done  = 1'b0;
      drain = m_valid & pready;
      if (rst) begin
         m_bits.delete();
         m_ord   = 1'b0;
         m_pout  = '0;
         m_valid = 1'b0;
         m_over  = 1'b0;
         return;
      end
      if (clr) begin
         m_bits.delete();
         m_over = 1'b0;
      end else if (en) begin
         if (m_bits.size() == 0) m_ord = dir;
         m_bits.push_back(sin);
         if (m_bits.size() == W) begin
            word = '0;
            for (int i = 0; i < W; i++) begin
               if (m_ord == 1'b0) word[i] = m_bits[i];
               else               word[W-1-i] = m_bits[i];
            end
            m_bits.delete();
            done = 1'b1;
            if (!m_valid || pready) begin
               m_pout  = word;
               m_valid = 1'b1;
            end else begin
               m_over = 1'b1;
            end
         end
      end
      if (!done && drain) m_valid = 1'b0;
   endtask

   // Drive one cycle, advance model on the edge, compare #1 later.
   task automatic step(input logic e, input logic s, input logic d,
                       input logic c, input logic pr, input logic r);
      en = e; sin = s; dir = d; clr = c; pready = pr; rst = r;
      @(posedge clk);
      model_update();
      #1;
      chk("model_pout",    32'(pout),    32'(m_pout));
      chk("model_pvalid",  32'(pvalid),  32'(m_valid));
      chk("model_overrun", 32'(overrun), 32'(m_over));
      chk("model_bitcnt",  32'(bitcnt),  32'(m_bits.size()));
   endtask

   // seq[7] is sent first
   task automatic send_seq(input logic [7:0] seq, input logic d, input logic pr);
      for (int i = 0; i < 8; i++) step(1'b1, seq[7-i], d, 1'b0, pr, 1'b0);
   endtask

   initial begin
      logic [7:0] s;
      vt[0] = '{seq: 8'hB2, d: 1'b0, exp: 8'h4D};
      vt[1] = '{seq: 8'hB2, d: 1'b1, exp: 8'hB2};
      vt[2] = '{seq: 8'h01, d: 1'b0, exp: 8'h80};
      vt[3] = '{seq: 8'h01, d: 1'b1, exp: 8'h01};
      vt[4] = '{seq: 8'hFF, d: 1'b0, exp: 8'hFF};
      vt[5] = '{seq: 8'h0F, d: 1'b0, exp: 8'hF0};
      vt[6] = '{seq: 8'hC3, d: 1'b1, exp: 8'hC3};

      en = 0; sin = 0; dir = 0; clr = 0; pready = 0; rst = 1;
      m_ord = 0; m_pout = '0; m_valid = 0; m_over = 0;
      @(negedge clk);

      // Reset state
      step(0, 0, 0, 0, 0, 1);
      chk("rst_pout", 32'(pout), 0);
      chk("rst_pvalid", 32'(pvalid), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_bitcnt", 32'(bitcnt), 0);

      // Vector table: one word each, consumer always ready
      for (int k = 0; k < 7; k++) begin
         send_seq(vt[k].seq, vt[k].d, 1'b1);
         chk("vec_pout", 32'(pout), 32'(vt[k].exp));
         chk("vec_pvalid", 32'(pvalid), 1);
         chk("vec_overrun", 32'(overrun), 0);
         step(0, 0, 0, 0, 1, 0);
         chk("vec_drain", 32'(pvalid), 0);
      end

      // dir toggled after bit 3 is ignored
      s = 8'hB2;
      for (int i = 0; i < 8; i++) step(1, s[7-i], (i < 3) ? 1'b1 : 1'b0, 0, 1, 0);
      chk("dirlatch_pout", 32'(pout), 32'hB2);
      step(0, 0, 0, 0, 1, 0);

      // Stall: second word dropped, overrun sticky until clr
      send_seq(8'hA5, 1'b1, 1'b0);
      chk("stall_pout1", 32'(pout), 32'hA5);
      send_seq(8'h3C, 1'b1, 1'b0);
      chk("stall_pout2", 32'(pout), 32'hA5);
      chk("stall_pvalid", 32'(pvalid), 1);
      chk("stall_overrun", 32'(overrun), 1);
      step(0, 0, 0, 0, 1, 0);
      chk("stall_drain", 32'(pvalid), 0);
      chk("stall_over_hold", 32'(overrun), 1);
      step(0, 0, 0, 1, 0, 0);
      chk("clr_overrun", 32'(overrun), 0);

      // Completion and drain on the same edge
      send_seq(8'h11, 1'b1, 1'b0);
      s = 8'h22;
      for (int i = 0; i < 7; i++) step(1, s[7-i], 1, 0, 0, 0);
      chk("simul_hold", 32'(pout), 32'h11);
      step(1, s[0], 1, 0, 1, 0);
      chk("simul_pout", 32'(pout), 32'h22);
      chk("simul_pvalid", 32'(pvalid), 1);
      chk("simul_overrun", 32'(overrun), 0);
      step(0, 0, 0, 0, 1, 0);

      // Gapped strobes, en every third cycle
      s = 8'h0F;
      for (int i = 0; i < 8; i++) begin
         step(1, s[7-i], 0, 0, 1, 0);
         if (i < 7) begin
            step(0, 1, 1, 0, 1, 0);
            step(0, 0, 1, 0, 1, 0);
            chk("gap_bitcnt", 32'(bitcnt), 32'(i + 1));
         end
      end
      chk("gap_pout", 32'(pout), 32'hF0);
      step(0, 0, 0, 0, 1, 0);

      // clr with en drops the partial word and the strobed bit
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1, 0);
      chk("abort_cnt5", 32'(bitcnt), 5);
      step(1, 1, 0, 1, 1, 0);
      chk("abort_bitcnt", 32'(bitcnt), 0);
      send_seq(8'h5A, 1'b1, 1'b1);
      chk("abort_clean", 32'(pout), 32'h5A);

      // Reset mid-word
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("midrst_pout", 32'(pout), 0);
      chk("midrst_pvalid", 32'(pvalid), 0);
      chk("midrst_bitcnt", 32'(bitcnt), 0);
      chk("midrst_overrun", 32'(overrun), 0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         step(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 99) < 3),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 199) < 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_deser8b.md
# serial_deser8b

Serial-to-parallel receiver that sits directly downstream of the universal 8-bit shift register and consumes its `sout` bit stream. It assembles `WIDTH` qualified bits into a word, in either LSB-first or MSB-first order, and presents the word on a valid/ready output port. A one-word holding register lets a slow consumer stall one word. Words that complete while the holding register is still full are dropped and flagged.

## Interface
Parameters:
- `WIDTH`, default 8: word width in bits; legal range 2..15.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `en`, in, 1: bit strobe; `sin` is sampled only in cycles where `en`=1.
- `sin`, in, 1: serial data bit.
- `dir`, in, 1: bit order. 0 = LSB first, which matches the upstream shift-right mode. 1 = MSB first, which matches the upstream shift-left mode.
- `clr`, in, 1: abort the partial word and clear `overrun`.
- `pout`, out, `WIDTH`: assembled word.
- `pvalid`, out, 1: `pout` holds an unconsumed word.
- `pready`, in, 1: consumer accepts `pout` when `pvalid`&`pready`.
- `overrun`, out, 1: sticky flag; a completed word was dropped.
- `bitcnt`, out, clog2(`WIDTH`+1): bits collected in the current partial word.

## Operation
- Reset, applied synchronously while `rst`=1:
  - `pout`=0, `pvalid`=0, `overrun`=0, `bitcnt`=0.
  - Assembly register = 0; latched order = 0.
- Order latch: `dir` is captured on the first accepted bit of a word (`en`=1 with `bitcnt`=0). Changes to `dir` mid-word are ignored until the next word starts.
- Accepted bit (`en`=1, `clr`=0, `rst`=0):
  - LSB first: asm <= {sin, asm[W-1:1]}.
  - MSB first: asm <= {asm[W-2:0], sin}.
  - `bitcnt` increments.
- Word completion: the accepted bit arrives with `bitcnt`=`WIDTH`-1.
  - `bitcnt` returns to 0.
  - The completed word is the shifted value including `sin`.
  - If `pvalid`=0, or the held word is drained in the same cycle (`pready`=1): `pout` <= completed word, `pvalid` <= 1.
  - Otherwise the completed word is discarded, `overrun` <= 1, and `pout`/`pvalid` are unchanged.
- Drain: when `pvalid`&`pready` and no word completes, `pvalid` <= 0 and `pout` holds its last value.
- `clr`=1:
  - `bitcnt` <= 0, asm <= 0, `overrun` <= 0.
  - `pout`/`pvalid` are unaffected; a drain in the same cycle still occurs.
  - `clr` takes priority over `en`: a bit strobed in the same cycle is discarded.
- `rst` takes priority over everything.
- Reset mid-word: the partial word is lost and no output is produced.

## Timing
- Latency: `pvalid` rises in the cycle after the edge that samples the `WIDTH`-th bit.
- Throughput: one bit per cycle; back-to-back words with no gap are supported.
- `bitcnt` updates on the same edge that samples the bit.
- Handshake:
  - `pout` is stable while `pvalid`=1 and no transfer occurs.
  - No combinational path exists from `pready` to `pvalid`.
  - `pvalid` never drops without a transfer, except on `rst`.
- Simultaneous completion and drain: `pvalid` stays 1 and `pout` takes the new word; there is no bubble and no overrun.
- `overrun` sets on the edge of the dropped completion and holds until `clr` or `rst`.
- All outputs are registered.

## Structure
- Shared package `shift_pkg`:
  - `DIR_LSB_FIRST`=1'b0, `DIR_MSB_FIRST`=1'b1.
  - Count-width function clog2(`WIDTH`+1), used for `bitcnt`.
  - These are reused by the shift-register controller.
- Sub-module `word_hold`:
  - One-entry valid/ready holding register with `load`, `data_in`, `full` outputs.
  - Instantiated once.
  - The top level keeps the bit counter, order latch, assembly register and overrun logic.

## Test plan
- Reset then LSB first, `dir`=0: bits 1,0,1,1,0,0,1,0 on consecutive `en` cycles, `pready`=1 → `pout`=8'h4D, `pvalid`=1 for one cycle, `overrun`=0.
- MSB first, `dir`=1: same bit sequence → `pout`=8'hB2. Toggle `dir` after bit 3 → word still 8'hB2, since order is latched.
- Stall: `pready`=0, feed two words, 8'hA5 then 8'h3C → `pout` stays 8'hA5, `overrun`=1 after the 16th bit. Then `pready`=1 → transfer, `pvalid`=0. Then `clr` → `overrun`=0.
- Simultaneous: hold 8'h11, and assert `pready` exactly on the completion edge of 8'h22 → `pout`=8'h22, `pvalid` stays 1, `overrun`=0.
- Gapped strobes: 8 bits of 8'hF0, LSB first, with `en` every third cycle → `pout`=8'hF0, and `bitcnt` holds during gaps.
- Abort/reset: after 5 bits assert `clr` together with `en` → `bitcnt`=0 and the bit is dropped; the next 8 bits form a clean word. Assert `rst` after 3 bits → all outputs 0 on the next edge.
